// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, target
// encoding, header field positions and the HALT opcode used by loaded programs.
package loader_pkg;
    typedef enum logic [2:0] {HDR, ADDR, DATA, CSUM, DONE, ERR} state_e;

    localparam logic        TARGET_IMEM = 1'b0;
    localparam logic        TARGET_DMEM = 1'b1;
    localparam int          TGT_BIT     = 15;
    localparam int          LEN_MSB     = 14;
    localparam logic [15:0] HALT_INSTR  = 16'b11100_00000000000;
endpackage

// File: rtl/prog_loader_if.sv
// Stream input and memory write bus of the program loader; the loader uses
// the master view, the stream source and memory side use the slave view.
interface prog_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, dmem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, dmem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader_csum.sv
// Modular running sum of accepted stream words; clear has priority over enable.
module loader_csum #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_word,
    output logic [DATA_W-1:0] o_sum
);
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (i_clr)
            r_sum <= '0;
        else if (i_en)
            r_sum <= r_sum + i_word;
    end

    assign o_sum = r_sum;
endmodule

// File: rtl/prog_loader.sv
// Stream-driven memory loader: parses header/address/data frames, writes
// imem/dmem, verifies a trailing checksum and then releases the CPU reset.
module prog_loader
    import loader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 15
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.master bus,
    input  logic          load_req,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);
    state_e              r_state;
    state_e              w_state_nxt;
    logic                w_accept;
    logic                w_wr;
    logic                w_restart;
    logic [LEN_W-1:0]    w_len;
    logic [DATA_W-1:0]   w_sum;

    logic                r_in_ready;
    logic                r_imem_we;
    logic                r_dmem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_reset;
    logic                r_done;
    logic                r_error;
    logic [LEN_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_target;

    loader_csum #(.DATA_W(DATA_W)) u_csum (
        .clk    (clk),
        .i_clr  (reset || w_restart),
        .i_en   (w_accept && (r_state != CSUM)),
        .i_word (bus.in_data),
        .o_sum  (w_sum)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= HDR;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_accept    = bus.in_valid && r_in_ready;
        w_len       = bus.in_data[LEN_MSB:0];
        w_wr        = w_accept && (r_state == DATA);
        w_restart   = load_req && ((r_state == DONE) || (r_state == ERR));
        w_state_nxt = r_state;
        case (r_state)
            HDR:  if (w_accept) w_state_nxt = (w_len != '0) ? ADDR : CSUM;
            ADDR: if (w_accept) w_state_nxt = DATA;
            DATA: if (w_accept && (r_count == LEN_W'(1))) w_state_nxt = HDR;
            CSUM: if (w_accept) w_state_nxt = (bus.in_data == w_sum) ? DONE : ERR;
            DONE: if (load_req) w_state_nxt = HDR;
            ERR:  if (load_req) w_state_nxt = HDR;
            default: w_state_nxt = HDR;
        endcase
    end

    // Registered handshake, write port and status; the write lands the cycle after its DATA handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_imem_we   <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_count     <= '0;
            r_addr      <= '0;
            r_target    <= TARGET_IMEM;
        end else begin
            r_in_ready  <= (w_state_nxt inside {HDR, ADDR, DATA, CSUM});
            r_imem_we   <= w_wr && (r_target == TARGET_IMEM);
            r_dmem_we   <= w_wr && (r_target == TARGET_DMEM);
            r_done      <= (r_state == DONE) && !load_req;
            r_cpu_reset <= !((r_state == DONE) && !load_req);
            r_error     <= (r_state == ERR) && !load_req;
            if (w_wr) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= bus.in_data;
                r_addr      <= r_addr + 1'b1;
                r_count     <= r_count - 1'b1;
            end else if (w_restart) begin
                r_count <= '0;
            end else if (w_accept && (r_state == HDR) && (w_len != '0)) begin
                r_count  <= w_len;
                r_target <= bus.in_data[TGT_BIT];
            end else if (w_accept && (r_state == ADDR)) begin
                r_addr <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.imem_we   = r_imem_we;
    assign bus.dmem_we   = r_dmem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign cpu_reset     = r_cpu_reset;
    assign done          = r_done;
    assign error         = r_error;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: stream driver, write scoreboard with a
// memory model, table-driven single-word frames and hand-written corner cases.
module tb_prog_loader;
    import loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic load_req;
    logic cpu_reset, done, error;

    prog_loader_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .load_req  (load_req),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tgt;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic        tgt;
        logic [15:0] addr;
        logic [15:0] data;
        logic        exp_imem_we;
        logic        exp_dmem_we;
    } vec_t;

    wr_t         exp_q[$];
    logic [15:0] imem_m [int];
    logic [15:0] dmem_m [int];
    logic [15:0] sum;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Write monitor: every enable pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.imem_we && bus.dmem_we) begin
            chk("both_we_high", 32'd1, 32'd0);
        end else if (bus.imem_we || bus.dmem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {bus.dmem_we, bus.mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write", {15'd0, bus.dmem_we, bus.mem_addr, bus.mem_wdata},
                    {15'd0, e.tgt, e.addr, e.data});
            end
            if (bus.imem_we) imem_m[int'(bus.mem_addr)] = bus.mem_wdata;
            else             dmem_m[int'(bus.mem_addr)] = bus.mem_wdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Drive one word, optionally after an idle cycle with garbage on in_data.
    task automatic send(input logic [15:0] w, input bit gap, input bit add);
        int t;
        t = 0;
        if (gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 16'hDEAD;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
            if (add) sum = sum + w;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic tgt, input logic [15:0] addr,
                              input logic [15:0] d[$], input bit gap);
        send({tgt, 15'(d.size())}, gap, 1'b1);
        send(addr, gap, 1'b1);
        for (int i = 0; i < d.size(); i++) begin
            exp_q.push_back({tgt, addr + 16'(i), d[i]});
            send(d[i], gap, 1'b1);
        end
    endtask

    task automatic finish_load(input logic [15:0] bad);
        send(16'h0000, 1'b0, 1'b1);
        send(sum + bad, 1'b0, 1'b0);
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        sum = '0;
    endtask

    task automatic expect_done(input string nm);
        @(posedge clk); #1;
        chk({nm, "_done"}, {31'd0, done}, 32'd1);
        chk({nm, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
        chk({nm, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        vec_t        vt[4];
        logic [15:0] d[$];
        logic [15:0] prog[$];
        logic [15:0] dat[$];

        vt[0] = '{TARGET_IMEM, 16'h0000, 16'hA5A5, 1'b1, 1'b0};
        vt[1] = '{TARGET_DMEM, 16'hFFFF, 16'h0001, 1'b0, 1'b1};
        vt[2] = '{TARGET_IMEM, 16'h7FFF, HALT_INSTR, 1'b1, 1'b0};
        vt[3] = '{TARGET_DMEM, 16'h1234, 16'hFFFF, 1'b0, 1'b1};

        reset        = 1'b1;
        load_req     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        sum          = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_we", {30'd0, bus.imem_we, bus.dmem_we}, 32'd0);
        chk("rst_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 32'd0);
        chk("rst_status", {29'd0, cpu_reset, done, error}, 32'b100);
        reset = 1'b0;
        chk("in_ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        // Single imem frame with the literal checksum.
        exp_q.push_back({TARGET_IMEM, 16'h0000, 16'h1111});
        exp_q.push_back({TARGET_IMEM, 16'h0001, 16'h2222});
        exp_q.push_back({TARGET_IMEM, 16'h0002, 16'hE000});
        send(16'h0003, 1'b0, 1'b0);
        send(16'h0000, 1'b0, 1'b0);
        send(16'h1111, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b0);
        send(16'hE000, 1'b0, 1'b0);
        chk("t1_last_write", {15'd0, bus.imem_we, bus.mem_addr}, {15'd0, 1'b1, 16'h0002});
        send(16'h0000, 1'b0, 1'b0);
        chk("t1_we_one_cycle", {30'd0, bus.imem_we, bus.dmem_we}, 32'd0);
        chk("t1_hold", {bus.mem_addr, bus.mem_wdata}, {16'h0002, 16'hE000});
        send(16'h1336, 1'b0, 1'b0);
        chk("t1_not_yet_done", {29'd0, cpu_reset, done, bus.in_ready}, 32'b100);
        expect_done("t1");
        chk("t1_idle_in_ready", {31'd0, bus.in_ready}, 32'd0);

        // Mixed imem/dmem frames.
        pulse_load_req();
        chk("lr_status", {29'd0, cpu_reset, done, bus.in_ready}, 32'b101);
        d = '{16'hBEEF};
        send_frame(TARGET_IMEM, 16'h0010, d, 1'b0);
        d = '{16'h0005, 16'h0007};
        send_frame(TARGET_DMEM, 16'h0100, d, 1'b0);
        finish_load(16'h0000);
        expect_done("t2");

        // Bad checksum, then a good reload.
        pulse_load_req();
        d = '{16'h0042};
        send_frame(TARGET_DMEM, 16'h0020, d, 1'b0);
        finish_load(16'h0001);
        @(posedge clk); #1;
        chk("t3_err_status", {28'd0, error, cpu_reset, done, bus.in_ready}, 32'b1100);
        @(posedge clk); #1;
        chk("t3_err_hold", {30'd0, error, cpu_reset}, 32'b11);
        pulse_load_req();
        chk("t3_err_cleared", {30'd0, error, bus.in_ready}, 32'b01);
        d = '{16'h0043, 16'h0044};
        send_frame(TARGET_DMEM, 16'h0020, d, 1'b0);
        finish_load(16'h0000);
        expect_done("t3");

        // Address wrap with in_valid toggling every cycle.
        pulse_load_req();
        d = '{16'h0AAA, 16'h0BBB};
        send_frame(TARGET_DMEM, 16'hFFFF, d, 1'b1);
        send(16'h0000, 1'b1, 1'b1);
        send(sum, 1'b1, 1'b0);
        expect_done("t4");

        // Table-driven single-word frames.
        pulse_load_req();
        for (int i = 0; i < 4; i++) begin
            d = '{vt[i].data};
            send_frame(vt[i].tgt, vt[i].addr, d, 1'b0);
            chk($sformatf("vec%0d_we", i), {30'd0, bus.imem_we, bus.dmem_we},
                {30'd0, vt[i].exp_imem_we, vt[i].exp_dmem_we});
            chk($sformatf("vec%0d_bus", i), {bus.mem_addr, bus.mem_wdata},
                {vt[i].addr, vt[i].data});
        end
        finish_load(16'h0000);
        expect_done("vec");

        // Reset after the first of three data words.
        pulse_load_req();
        send({TARGET_DMEM, 15'd3}, 1'b0, 1'b1);
        send(16'h0200, 1'b0, 1'b1);
        exp_q.push_back({TARGET_DMEM, 16'h0200, 16'h0101});
        send(16'h0101, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_we_cleared", {30'd0, bus.imem_we, bus.dmem_we}, 32'd0);
        chk("t5_cpu_reset", {30'd0, cpu_reset, bus.in_ready}, 32'b10);
        chk("t5_no_pending", exp_q.size(), 32'd0);
        reset = 1'b0;
        sum   = '0;
        @(posedge clk); #1;
        d = '{16'h0301, 16'h0302, 16'h0303};
        send_frame(TARGET_DMEM, 16'h0200, d, 1'b0);
        finish_load(16'h0000);
        expect_done("t5");

        // End-to-end program ending in HALT, checked against the memory model.
        pulse_load_req();
        prog = '{16'h1234, 16'h5678, HALT_INSTR};
        dat  = '{16'h00AA, 16'h00BB};
        send_frame(TARGET_IMEM, 16'h0040, prog, 1'b0);
        send_frame(TARGET_DMEM, 16'h0300, dat, 1'b0);
        finish_load(16'h0000);
        expect_done("t6");
        for (int i = 0; i < prog.size(); i++)
            chk($sformatf("dump_imem%0d", i), {16'd0, imem_m[32'h40 + i]}, {16'd0, prog[i]});
        for (int i = 0; i < dat.size(); i++)
            chk($sformatf("dump_dmem%0d", i), {16'd0, dmem_m[32'h300 + i]}, {16'd0, dat[i]});
        chk("dump_wrap_ffff", {16'd0, dmem_m[32'hFFFF]}, {16'd0, 16'h0001});
        chk("dump_wrap_0000", {16'd0, dmem_m[0]}, {16'd0, 16'h0BBB});
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
